fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: IMEM_BASE, 32'h0000_0000, reset fetch address.
REQ-002 Parameter: NOP_INSN, 32'h0000_0013, instruction word presented while VALID_IF=0.
REQ-003 Port: CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Port: RSTN  in  1  asynchronous, active-low reset.
REQ-005 Port: STALL  in  1  downstream stage cannot accept a new instruction this cycle.
REQ-006 Port: REDIRECT  in  1  branch/jump taken; restart fetch at REDIRECT_PC.
REQ-007 Port: REDIRECT_PC  in  32  redirect target byte address.
REQ-008 Port: IMEM_REQ  out  1  registered instruction memory read request.
REQ-009 Port: IMEM_ADDR  out  32  registered word-aligned read address.
REQ-010 Port: IMEM_ACK  in  1  memory returns IMEM_RDATA for IMEM_ADDR this cycle.
REQ-011 Port: IMEM_RDATA  in  32  read data, valid only when IMEM_ACK=1.
REQ-012 Port: PC_IF  out  32  address of the instruction on IDATA_IF.
REQ-013 Port: IDATA_IF  out  32  fetched instruction to decode.
REQ-014 Port: VALID_IF  out  1  PC_IF/IDATA_IF hold a real instruction.
REQ-015 Port: FETCH_CNT  out  32  count of instructions delivered with VALID_IF=1.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, HOLD, KILL.
REQ-017 A transfer SHALL complete on a rising edge where IMEM_REQ=1 and IMEM_ACK=1; IMEM_ACK while IMEM_REQ=0 SHALL be ignored.
REQ-018 While IMEM_REQ=1 and no transfer completes, IMEM_ADDR SHALL remain stable.
REQ-019 IDLE: one cycle after reset release; next state FETCH with IMEM_REQ=1, IMEM_ADDR=IMEM_BASE.
REQ-020 FETCH, ACK, STALL=0, REDIRECT=0: PC_IF<=IMEM_ADDR, IDATA_IF<=IMEM_RDATA, VALID_IF<=1, IMEM_ADDR<=IMEM_ADDR+4, IMEM_REQ stays 1 (one instruction per cycle under continuous ACK).
REQ-021 FETCH, no ACK, STALL=0, REDIRECT=0: VALID_IF<=0, IDATA_IF<=NOP_INSN, PC_IF unchanged (bubble).
REQ-022 STALL=1 (REDIRECT=0): PC_IF, IDATA_IF, VALID_IF SHALL hold their values.
REQ-023 FETCH, ACK, STALL=1: response SHALL be captured into a one-entry buffer with its address; IMEM_REQ<=0; IMEM_ADDR<=address+4; next state HOLD.
REQ-024 HOLD, STALL=0: buffer moves to PC_IF/IDATA_IF with VALID_IF<=1, IMEM_REQ<=1, next state FETCH; HOLD with STALL=1 SHALL remain HOLD.
REQ-025 REDIRECT SHALL take priority over STALL and over any ACK data; on REDIRECT: VALID_IF<=0, IDATA_IF<=NOP_INSN, buffer discarded, target register <= {REDIRECT_PC[31:2],2'b00}.
REQ-026 REDIRECT with no request outstanding, or coincident with ACK: IMEM_ADDR<=target, IMEM_REQ<=1, next state FETCH; ACK data that cycle SHALL be discarded.
REQ-027 REDIRECT while IMEM_REQ=1 and no ACK: next state KILL; IMEM_REQ and IMEM_ADDR unchanged.
REQ-028 KILL: VALID_IF=0; on ACK the data SHALL be discarded, IMEM_ADDR<=target, next state FETCH; a further REDIRECT in KILL SHALL overwrite the target.
REQ-029 PC and address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-030 FETCH_CNT SHALL increment by 1 on each edge where VALID_IF transitions into, or is reloaded as, a new valid instruction (REQ-020, REQ-024), wrapping at 2^32.

Reset
REQ-031 RSTN=0 SHALL immediately force: state IDLE, IMEM_REQ=0, IMEM_ADDR=IMEM_BASE, PC_IF=IMEM_BASE, IDATA_IF=NOP_INSN, VALID_IF=0, FETCH_CNT=0, buffer empty, target=IMEM_BASE.
REQ-032 Reset asserted mid-transfer SHALL abandon the outstanding request; any IMEM_ACK during reset SHALL be ignored.

Verification
REQ-033 Reset, ACK tied 1, mem[i]=i: VALID_IF from cycle 3, PC_IF 0,4,8,... with IDATA_IF 0,1,2,...; FETCH_CNT=10 after 10 valid cycles.
REQ-034 ACK every third cycle: VALID_IF pattern 0,0,1 repeating; IMEM_ADDR stable during wait cycles; no instruction skipped or duplicated.
REQ-035 STALL=1 for 3 cycles while ACK returns addr 0x10: outputs frozen, IMEM_REQ=0 in HOLD, then PC_IF=0x10 on release followed by 0x14.
REQ-036 REDIRECT to 0x103 while request for 0x20 pending without ACK: KILL, ACK data for 0x20 dropped, next IMEM_ADDR=0x100, first valid PC_IF=0x100.
REQ-037 REDIRECT and STALL both 1 with ACK: VALID_IF=0, IDATA_IF=NOP_INSN, IMEM_ADDR=target next cycle.
REQ-038 RSTN pulsed low mid-FETCH at IMEM_ADDR=0x40: outputs return to reset values asynchronously; fetch restarts at IMEM_BASE.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and its memory.
// The master issues a registered request/address; the slave returns data with an ack.
interface fetch_ctrl_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;

  modport master (output IMEM_REQ, output IMEM_ADDR, input IMEM_ACK, input IMEM_RDATA);
  modport slave  (input IMEM_REQ, input IMEM_ADDR, output IMEM_ACK, output IMEM_RDATA);
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: streams words from IMEM into the IF stage,
// with a one-entry skid buffer for stalls and redirect/kill handling.
module fetch_ctrl #(
  parameter logic [31:0] IMEM_BASE = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          STALL,
  input  logic          REDIRECT,
  input  logic [31:0]   REDIRECT_PC,
  fetch_ctrl_if.master  imem,
  output logic [31:0]   PC_IF,
  output logic [31:0]   IDATA_IF,
  output logic          VALID_IF,
  output logic [31:0]   FETCH_CNT
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, KILL} state_t;

  state_t      state, state_n;
  logic        req, req_n;
  logic [31:0] addr, addr_n;
  logic [31:0] pc, pc_n;
  logic [31:0] idata, idata_n;
  logic        valid, valid_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] buf_data, buf_data_n;
  logic [31:0] target, target_n;
  logic        xfer;
  logic [31:0] redir_tgt;

  assign xfer      = req & imem.IMEM_ACK;
  assign redir_tgt = REDIRECT_PC & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      req      <= 1'b0;
      addr     <= IMEM_BASE;
      pc       <= IMEM_BASE;
      idata    <= NOP_INSN;
      valid    <= 1'b0;
      cnt      <= '0;
      buf_pc   <= '0;
      buf_data <= '0;
      target   <= IMEM_BASE;
    end else begin
      state    <= state_n;
      req      <= req_n;
      addr     <= addr_n;
      pc       <= pc_n;
      idata    <= idata_n;
      valid    <= valid_n;
      cnt      <= cnt_n;
      buf_pc   <= buf_pc_n;
      buf_data <= buf_data_n;
      target   <= target_n;
    end
  end

  always_comb begin
    state_n    = state;
    req_n      = req;
    addr_n     = addr;
    pc_n       = pc;
    idata_n    = idata;
    valid_n    = valid;
    cnt_n      = cnt;
    buf_pc_n   = buf_pc;
    buf_data_n = buf_data;
    target_n   = target;

    if (REDIRECT) begin
      // Redirect beats stall and any returning data; the buffer is dropped by leaving HOLD.
      valid_n  = 1'b0;
      idata_n  = NOP_INSN;
      target_n = redir_tgt;
      if (req && !imem.IMEM_ACK) begin
        // Request in flight: keep the bus stable until the stale response drains.
        state_n = KILL;
      end else begin
        addr_n  = redir_tgt;
        req_n   = 1'b1;
        state_n = FETCH;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state_n = FETCH;
          req_n   = 1'b1;
          addr_n  = IMEM_BASE;
        end
        FETCH: begin
          if (STALL) begin
            if (xfer) begin
              buf_pc_n   = addr;
              buf_data_n = imem.IMEM_RDATA;
              req_n      = 1'b0;
              addr_n     = addr + 32'd4;
              state_n    = HOLD;
            end
          end else if (xfer) begin
            pc_n    = addr;
            idata_n = imem.IMEM_RDATA;
            valid_n = 1'b1;
            addr_n  = addr + 32'd4;
            cnt_n   = cnt + 32'd1;
          end else begin
            valid_n = 1'b0;
            idata_n = NOP_INSN;
          end
        end
        HOLD: begin
          if (!STALL) begin
            pc_n    = buf_pc;
            idata_n = buf_data;
            valid_n = 1'b1;
            req_n   = 1'b1;
            cnt_n   = cnt + 32'd1;
            state_n = FETCH;
          end
        end
        KILL: begin
          valid_n = 1'b0;
          if (xfer) begin
            addr_n  = target;
            state_n = FETCH;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign imem.IMEM_REQ  = req;
  assign imem.IMEM_ADDR = addr;
  assign PC_IF          = pc;
  assign IDATA_IF       = idata;
  assign VALID_IF       = valid;
  assign FETCH_CNT      = cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; memory returns word index (addr>>2) as data.
module tb_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK, RSTN, STALL, REDIRECT;
  logic [31:0] REDIRECT_PC, PC_IF, IDATA_IF, FETCH_CNT;
  logic        VALID_IF;
  int          n_chk, n_fail;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .CLK(CLK), .RSTN(RSTN), .STALL(STALL), .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC), .imem(bus.master),
    .PC_IF(PC_IF), .IDATA_IF(IDATA_IF), .VALID_IF(VALID_IF), .FETCH_CNT(FETCH_CNT)
  );

  assign bus.IMEM_RDATA = bus.IMEM_ADDR >> 2;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},   {31'd0, bus.IMEM_REQ}, 32'd0);
    chk({tag, ".addr"},  bus.IMEM_ADDR, 32'd0);
    chk({tag, ".pc"},    PC_IF, 32'd0);
    chk({tag, ".idata"}, IDATA_IF, NOP);
    chk({tag, ".valid"}, {31'd0, VALID_IF}, 32'd0);
    chk({tag, ".cnt"},   FETCH_CNT, 32'd0);
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    step();
    step();
    RSTN = 1'b1;
  endtask

  logic [31:0] exp_pc;

  initial begin
    n_chk = 0; n_fail = 0;
    RSTN = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = '0;
    bus.IMEM_ACK = 1'b1;

    // Reset, ACK held high throughout (ignored while in reset)
    step(); step();
    chk_reset_vals("rst");
    RSTN = 1'b1;
    step();
    chk("idle.req",   {31'd0, bus.IMEM_REQ}, 32'd1);
    chk("idle.addr",  bus.IMEM_ADDR, 32'd0);
    chk("idle.valid", {31'd0, VALID_IF}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("stream.pc%0d", i),    PC_IF, 32'(4 * i));
      chk($sformatf("stream.data%0d", i),  IDATA_IF, 32'(i));
      chk($sformatf("stream.valid%0d", i), {31'd0, VALID_IF}, 32'd1);
    end
    chk("stream.cnt", FETCH_CNT, 32'd10);

    // ACK every third cycle from address 0x28
    exp_pc = 32'h28;
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) begin
        bus.IMEM_ACK = (k == 2);
        step();
        chk($sformatf("sparse.valid%0d_%0d", g, k), {31'd0, VALID_IF}, (k == 2) ? 32'd1 : 32'd0);
        if (k != 2) begin
          chk($sformatf("sparse.addr%0d_%0d", g, k), bus.IMEM_ADDR, exp_pc);
          chk($sformatf("sparse.nop%0d_%0d", g, k), IDATA_IF, NOP);
        end else begin
          chk($sformatf("sparse.pc%0d", g),   PC_IF, exp_pc);
          chk($sformatf("sparse.data%0d", g), IDATA_IF, exp_pc >> 2);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    chk("sparse.cnt", FETCH_CNT, 32'd13);

    // Stall while the 0x10 response returns
    bus.IMEM_ACK = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("stall.pre_pc",   PC_IF, 32'h0C);
    chk("stall.pre_addr", bus.IMEM_ADDR, 32'h10);
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall.pc%0d", i),    PC_IF, 32'h0C);
      chk($sformatf("stall.data%0d", i),  IDATA_IF, 32'd3);
      chk($sformatf("stall.valid%0d", i), {31'd0, VALID_IF}, 32'd1);
      chk($sformatf("stall.req%0d", i),   {31'd0, bus.IMEM_REQ}, 32'd0);
    end
    STALL = 1'b0;
    step();
    chk("stall.rel_pc",   PC_IF, 32'h10);
    chk("stall.rel_data", IDATA_IF, 32'd4);
    chk("stall.rel_req",  {31'd0, bus.IMEM_REQ}, 32'd1);
    step();
    chk("stall.next_pc",  PC_IF, 32'h14);
    chk("stall.cnt",      FETCH_CNT, 32'd6);

    // Redirect to 0x103 while the 0x20 request waits for ACK
    step(); step();
    chk("kill.pre_addr", bus.IMEM_ADDR, 32'h20);
    bus.IMEM_ACK = 1'b0; REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
    step();
    REDIRECT = 1'b0;
    chk("kill.valid", {31'd0, VALID_IF}, 32'd0);
    chk("kill.nop",   IDATA_IF, NOP);
    chk("kill.addr",  bus.IMEM_ADDR, 32'h20);
    chk("kill.req",   {31'd0, bus.IMEM_REQ}, 32'd1);
    step();
    chk("kill.wait_addr", bus.IMEM_ADDR, 32'h20);
    bus.IMEM_ACK = 1'b1;
    step();
    chk("kill.drop_valid", {31'd0, VALID_IF}, 32'd0);
    chk("kill.new_addr",   bus.IMEM_ADDR, 32'h100);
    step();
    chk("kill.first_pc",   PC_IF, 32'h100);
    chk("kill.first_data", IDATA_IF, 32'h40);

    // Redirect + stall + ACK together
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200; STALL = 1'b1;
    step();
    REDIRECT = 1'b0; STALL = 1'b0;
    chk("rs.valid", {31'd0, VALID_IF}, 32'd0);
    chk("rs.nop",   IDATA_IF, NOP);
    chk("rs.addr",  bus.IMEM_ADDR, 32'h200);
    step();
    chk("rs.pc",  PC_IF, 32'h200);
    chk("rs.cnt", FETCH_CNT, 32'd10);

    // Address wrap at the top of memory
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFF_FFFF;
    step();
    REDIRECT = 1'b0;
    chk("wrap.addr", bus.IMEM_ADDR, 32'hFFFF_FFFC);
    step();
    chk("wrap.pc",    PC_IF, 32'hFFFF_FFFC);
    chk("wrap.next",  bus.IMEM_ADDR, 32'h0);

    // Asynchronous reset mid-fetch at 0x40
    do_reset();
    for (int i = 0; i < 17; i++) step();
    chk("arst.pre_addr", bus.IMEM_ADDR, 32'h40);
    #2 RSTN = 1'b0;
    #1;
    chk_reset_vals("arst");
    step();
    chk_reset_vals("arst_hold");
    RSTN = 1'b1;
    step();
    chk("arst.req",  {31'd0, bus.IMEM_REQ}, 32'd1);
    chk("arst.addr", bus.IMEM_ADDR, 32'd0);
    step();
    chk("arst.pc",   PC_IF, 32'd0);
    chk("arst.cnt",  FETCH_CNT, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
